scr1_pipe_mprf_wr_arb: RTL and testbench

//  Arbitrates the single MPRF write port between EXU writeback (IALU/CSR results) and

---
 rtl/scr1_pipe_mprf_wr_arb_pkg.sv | 19 +
 rtl/scr1_pipe_mprf_wr_fifo.sv | 108 ++++++++++
 rtl/scr1_pipe_mprf_wr_arb.sv | 139 +++++++++++++
 tb/tb_scr1_pipe_mprf_wr_arb.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scr1_pipe_mprf_wr_arb_pkg.sv
// Shared pipe types for the MPRF write-port arbiter: write request record and grant encoding.
// Build option SCR1_MPRF_WR_ARB_BYPASS_EN (see scr1_pipe_mprf_wr_arb.sv) does not affect this file.
package scr1_pipe_mprf_wr_arb_pkg;

   localparam int SCR1_MPRF_AWIDTH = 5;
   localparam int SCR1_MPRF_DWIDTH = 32;

   typedef struct packed {
      logic [SCR1_MPRF_AWIDTH-1:0] addr;
      logic [SCR1_MPRF_DWIDTH-1:0] data;
   } type_scr1_mprf_wr_req_s;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      EXU_GNT  = 2'd1,
      FIFO_GNT = 2'd2
   } type_scr1_wr_arb_gnt_e;

endpackage : scr1_pipe_mprf_wr_arb_pkg

// File: rtl/scr1_pipe_mprf_wr_fifo.sv
// Pending-load FIFO: pointers, count, full/empty and age-ordered rd compares (waw/rs1/rs2).
// With SCR1_MPRF_WR_ARB_BYPASS_EN defined it also returns the youngest matching entry's data.
module scr1_pipe_mprf_wr_fifo
   import scr1_pipe_mprf_wr_arb_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int AWIDTH = SCR1_MPRF_AWIDTH,
   parameter int DWIDTH = SCR1_MPRF_DWIDTH,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [AWIDTH-1:0] push_addr,
   input  logic [DWIDTH-1:0] push_data,
   input  logic              pop,
   input  logic [AWIDTH-1:0] waw_addr,
   input  logic [AWIDTH-1:0] rs1_addr,
   input  logic [AWIDTH-1:0] rs2_addr,
   output logic              empty,
   output logic              full,
   output logic [CW-1:0]     cnt,
   output logic [AWIDTH-1:0] head_addr,
   output logic [DWIDTH-1:0] head_data,
   output logic              waw_hit,
   output logic              rs1_hit,
`ifdef SCR1_MPRF_WR_ARB_BYPASS_EN
   output logic [DWIDTH-1:0] rs1_byp_data,
   output logic [DWIDTH-1:0] rs2_byp_data,
`endif
   output logic              rs2_hit
);

   logic [AWIDTH-1:0] addr_q [DEPTH];
   logic [DWIDTH-1:0] data_q [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     cnt_q;

   // Bit i of each vector refers to the i-th oldest entry (0 = head).
   logic [DEPTH-1:0]  vld_vec;
   logic [DEPTH-1:0]  waw_vec;
   logic [DEPTH-1:0]  rs1_vec;
   logic [DEPTH-1:0]  rs2_vec;
   logic [PW-1:0]     idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Storage needs no reset: entries beyond cnt_q are never looked at.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wr_ptr] <= push_addr;
         data_q[wr_ptr] <= push_data;
      end
   end

   always_comb begin
      vld_vec = '0;
      waw_vec = '0;
      rs1_vec = '0;
      rs2_vec = '0;
      idx     = '0;
`ifdef SCR1_MPRF_WR_ARB_BYPASS_EN
      rs1_byp_data = '0;
      rs2_byp_data = '0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
         idx        = rd_ptr + PW'(i);
         vld_vec[i] = (i < int'(cnt_q));
         waw_vec[i] = vld_vec[i] & (waw_addr != '0) & (addr_q[idx] == waw_addr);
         rs1_vec[i] = vld_vec[i] & (rs1_addr != '0) & (addr_q[idx] == rs1_addr);
         rs2_vec[i] = vld_vec[i] & (rs2_addr != '0) & (addr_q[idx] == rs2_addr);
`ifdef SCR1_MPRF_WR_ARB_BYPASS_EN
         // Ascending age order, so the last hit is the youngest writer.
         if (rs1_vec[i]) rs1_byp_data = data_q[idx];
         if (rs2_vec[i]) rs2_byp_data = data_q[idx];
`endif
      end
   end

   assign empty     = (cnt_q == '0);
   assign full      = (cnt_q == CW'(DEPTH));
   assign cnt       = cnt_q;
   assign head_addr = addr_q[rd_ptr];
   assign head_data = data_q[rd_ptr];
   assign waw_hit   = |waw_vec;
   assign rs1_hit   = |rs1_vec;
   assign rs2_hit   = |rs2_vec;

   a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
   a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule : scr1_pipe_mprf_wr_fifo

// File: rtl/scr1_pipe_mprf_wr_arb.sv
// MPRF write-port arbiter between EXU writeback and buffered LSU load returns (WAW-safe).
// Build option SCR1_MPRF_WR_ARB_BYPASS_EN: adds rs1/rs2 bypass ports and ties hzd_stall_o low.
//
// Handshake: an EXU request (exu_wb_vd_i) completes in the cycle exu_wb_rdy_o is high and must be
// held stable until then; an LSU return completes in the cycle lsu_wb_vd_i & lsu_wb_rdy_o.
module scr1_pipe_mprf_wr_arb
   import scr1_pipe_mprf_wr_arb_pkg::*;
#(
   parameter int FIFO_DEPTH = 2,
   parameter int STARVE_MAX = 4,
   parameter int AWIDTH     = SCR1_MPRF_AWIDTH,
   parameter int DWIDTH     = SCR1_MPRF_DWIDTH
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          exu_wb_vd_i,
   input  logic [AWIDTH-1:0]             exu_wb_addr_i,
   input  logic [DWIDTH-1:0]             exu_wb_data_i,
   output logic                          exu_wb_rdy_o,
   input  logic                          lsu_wb_vd_i,
   input  logic [AWIDTH-1:0]             lsu_wb_addr_i,
   input  logic [DWIDTH-1:0]             lsu_wb_data_i,
   output logic                          lsu_wb_rdy_o,
   output logic                          mprf_wr_en_o,
   output logic [AWIDTH-1:0]             mprf_wr_addr_o,
   output logic [DWIDTH-1:0]             mprf_wr_data_o,
   input  logic [AWIDTH-1:0]             rs1_addr_i,
   input  logic [AWIDTH-1:0]             rs2_addr_i,
   output logic                          hzd_stall_o,
`ifdef SCR1_MPRF_WR_ARB_BYPASS_EN
   output logic                          rs1_byp_vd_o,
   output logic [DWIDTH-1:0]             rs1_byp_data_o,
   output logic                          rs2_byp_vd_o,
   output logic [DWIDTH-1:0]             rs2_byp_data_o,
`endif
   output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);

   localparam int SW = $clog2(STARVE_MAX + 1);

   type_scr1_wr_arb_gnt_e gnt;
   logic [SW-1:0]         starve_q;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic [AWIDTH-1:0]     fifo_head_addr;
   logic [DWIDTH-1:0]     fifo_head_data;
   logic                  waw_hit;
   logic                  rs1_hit;
   logic                  rs2_hit;

   // Loads to x0 are acknowledged but dropped, so the FIFO never holds x0.
   assign fifo_push = lsu_wb_vd_i & ~fifo_full & (lsu_wb_addr_i != '0);
   assign fifo_pop  = (gnt == FIFO_GNT);

   scr1_pipe_mprf_wr_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .AWIDTH (AWIDTH),
      .DWIDTH (DWIDTH)
   ) i_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .push         (fifo_push),
      .push_addr    (lsu_wb_addr_i),
      .push_data    (lsu_wb_data_i),
      .pop          (fifo_pop),
      .waw_addr     (exu_wb_addr_i),
      .rs1_addr     (rs1_addr_i),
      .rs2_addr     (rs2_addr_i),
      .empty        (fifo_empty),
      .full         (fifo_full),
      .cnt          (fifo_cnt_o),
      .head_addr    (fifo_head_addr),
      .head_data    (fifo_head_data),
      .waw_hit      (waw_hit),
      .rs1_hit      (rs1_hit),
`ifdef SCR1_MPRF_WR_ARB_BYPASS_EN
      .rs1_byp_data (rs1_byp_data_o),
      .rs2_byp_data (rs2_byp_data_o),
`endif
      .rs2_hit      (rs2_hit)
   );

   // Held idle while rst_n is low so the write strobe drops together with the reset.
   always_comb begin
      gnt = IDLE;
      if (rst_n) begin
         if (!fifo_empty && (!exu_wb_vd_i || (starve_q == SW'(STARVE_MAX)) || waw_hit)) begin
            gnt = FIFO_GNT;
         end else if (exu_wb_vd_i) begin
            gnt = EXU_GNT;
         end
      end
   end

   always_comb begin
      mprf_wr_en_o   = 1'b0;
      mprf_wr_addr_o = '0;
      mprf_wr_data_o = '0;
      case (gnt)
         FIFO_GNT: begin
            mprf_wr_en_o   = 1'b1;
            mprf_wr_addr_o = fifo_head_addr;
            mprf_wr_data_o = fifo_head_data;
         end
         EXU_GNT: begin
            mprf_wr_en_o   = (exu_wb_addr_i != '0);
            mprf_wr_addr_o = exu_wb_addr_i;
            mprf_wr_data_o = exu_wb_data_i;
         end
         default: ;
      endcase
   end

   assign exu_wb_rdy_o = ~(exu_wb_vd_i & (gnt == FIFO_GNT));
   assign lsu_wb_rdy_o = ~fifo_full;

   // Counts cycles a waiting load loses to EXU; reaching STARVE_MAX forces the FIFO through.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_q <= '0;
      end else if (fifo_empty || (gnt == FIFO_GNT)) begin
         starve_q <= '0;
      end else if ((gnt == EXU_GNT) && (starve_q != SW'(STARVE_MAX))) begin
         starve_q <= starve_q + 1'b1;
      end
   end

`ifdef SCR1_MPRF_WR_ARB_BYPASS_EN
   assign hzd_stall_o  = 1'b0;
   assign rs1_byp_vd_o = rs1_hit;
   assign rs2_byp_vd_o = rs2_hit;
`else
   // The entry being popped still stalls: its MPRF write lands on the next edge.
   assign hzd_stall_o  = rs1_hit | rs2_hit;
`endif

endmodule : scr1_pipe_mprf_wr_arb

// File: tb/tb_scr1_pipe_mprf_wr_arb.sv
// Bench for scr1_pipe_mprf_wr_arb: directed scenarios plus randomized traffic against a queue model.
// Honours SCR1_MPRF_WR_ARB_BYPASS_EN to connect and check the bypass ports.
module tb_scr1_pipe_mprf_wr_arb;
  import scr1_pipe_mprf_wr_arb_pkg::*;

  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exu_vd;
  logic [4:0]  exu_addr;
  logic [31:0] exu_data;
  logic        exu_rdy;
  logic        lsu_vd;
  logic [4:0]  lsu_addr;
  logic [31:0] lsu_data;
  logic        lsu_rdy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        stall;
  logic [1:0]  cnt;
`ifdef SCR1_MPRF_WR_ARB_BYPASS_EN
  logic        b1_vd;
  logic [31:0] b1_data;
  logic        b2_vd;
  logic [31:0] b2_data;
`endif

  scr1_pipe_mprf_wr_arb #(.FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX), .AWIDTH(5), .DWIDTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .exu_wb_vd_i    (exu_vd),
    .exu_wb_addr_i  (exu_addr),
    .exu_wb_data_i  (exu_data),
    .exu_wb_rdy_o   (exu_rdy),
    .lsu_wb_vd_i    (lsu_vd),
    .lsu_wb_addr_i  (lsu_addr),
    .lsu_wb_data_i  (lsu_data),
    .lsu_wb_rdy_o   (lsu_rdy),
    .mprf_wr_en_o   (wr_en),
    .mprf_wr_addr_o (wr_addr),
    .mprf_wr_data_o (wr_data),
    .rs1_addr_i     (rs1),
    .rs2_addr_i     (rs2),
    .hzd_stall_o    (stall),
`ifdef SCR1_MPRF_WR_ARB_BYPASS_EN
    .rs1_byp_vd_o   (b1_vd),
    .rs1_byp_data_o (b1_data),
    .rs2_byp_vd_o   (b2_vd),
    .rs2_byp_data_o (b2_data),
`endif
    .fifo_cnt_o     (cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  type_scr1_mprf_wr_req_s pend[$];   // loads waiting for the write port, oldest first
  int          m_starve;
  logic [31:0] dut_rf [32];          // register file as written by the DUT's write port

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_pending(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (pend[i]) if (pend[i].addr == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_youngest(input logic [4:0] a);
    logic [31:0] d = '0;
    foreach (pend[i]) if (a != 5'd0 && pend[i].addr == a) d = pend[i].data;
    return d;
  endfunction

  // The load queue takes the port when EXU is absent, when it has waited SMAX cycles, or to keep rd order.
  function automatic bit m_fifo_wins();
    return (pend.size() != 0) && (!exu_vd || m_starve == SMAX || m_pending(exu_addr));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend.delete();
      m_starve <= 0;
    end else begin
      automatic int  sz = pend.size();
      automatic bit  fw = m_fifo_wins();
      automatic type_scr1_mprf_wr_req_s r;
      if (fw) void'(pend.pop_front());
      if (lsu_vd && sz < DEPTH && lsu_addr != 5'd0) begin
        r.addr = lsu_addr;
        r.data = lsu_data;
        pend.push_back(r);
      end
      if (fw || sz == 0)                m_starve <= 0;
      else if (exu_vd && m_starve < SMAX) m_starve <= m_starve + 1;
    end
  end

  always @(posedge clk) if (wr_en) dut_rf[wr_addr] <= wr_data;

  always @(negedge clk) begin
    if (chk_on) begin
      automatic bit fw = rst_n && m_fifo_wins();
      automatic bit ew = rst_n && !fw && exu_vd;
      if (fw) begin
        chk("m_wr_en", 32'(wr_en), 32'd1);
        chk("m_wr_addr", 32'(wr_addr), 32'(pend[0].addr));
        chk("m_wr_data", wr_data, pend[0].data);
      end else if (ew) begin
        chk("m_wr_en", 32'(wr_en), 32'(exu_addr != 5'd0));
        if (exu_addr != 5'd0) begin
          chk("m_wr_addr", 32'(wr_addr), 32'(exu_addr));
          chk("m_wr_data", wr_data, exu_data);
        end
      end else begin
        chk("m_wr_en", 32'(wr_en), 32'd0);
        if (!rst_n) begin
          chk("m_rst_addr", 32'(wr_addr), 32'd0);
          chk("m_rst_data", wr_data, 32'd0);
        end
      end
      chk("m_exu_rdy", 32'(exu_rdy), 32'(!(exu_vd && fw)));
      chk("m_lsu_rdy", 32'(lsu_rdy), 32'(pend.size() < DEPTH));
      chk("m_cnt", 32'(cnt), 32'(pend.size()));
`ifdef SCR1_MPRF_WR_ARB_BYPASS_EN
      chk("m_stall", 32'(stall), 32'd0);
      chk("m_b1_vd", 32'(b1_vd), 32'(m_pending(rs1)));
      chk("m_b2_vd", 32'(b2_vd), 32'(m_pending(rs2)));
      if (m_pending(rs1)) chk("m_b1_data", b1_data, m_youngest(rs1));
      if (m_pending(rs2)) chk("m_b2_data", b2_data, m_youngest(rs2));
`else
      chk("m_stall", 32'(stall), 32'(m_pending(rs1) || m_pending(rs2)));
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic exu_set(input logic v, input logic [4:0] a, input logic [31:0] d);
    exu_vd = v; exu_addr = a; exu_data = d;
  endtask

  task automatic lsu_set(input logic v, input logic [4:0] a, input logic [31:0] d);
    lsu_vd = v; lsu_addr = a; lsu_data = d;
  endtask

  task automatic drain();
    exu_set(1'b0, 5'd0, 32'd0);
    lsu_set(1'b0, 5'd0, 32'd0);
    repeat (4) next_cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    bit hold;
    rst_n = 1'b0;
    exu_set(1'b0, 5'd0, 32'd0);
    lsu_set(1'b0, 5'd0, 32'd0);
    rs1 = 5'd0; rs2 = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_lsu_rdy", 32'(lsu_rdy), 32'd1);
    chk("rst_wr_en", 32'(wr_en), 32'd0);

    // EXU only, then an x0 request
    exu_set(1'b1, 5'd3, 32'h11);
    next_cyc();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t2_en", 32'(wr_en), 32'd1);
      chk("t2_addr", 32'(wr_addr), 32'd3);
      chk("t2_data", wr_data, 32'h11);
      chk("t2_rdy", 32'(exu_rdy), 32'd1);
      next_cyc();
    end
    exu_set(1'b1, 5'd0, 32'h22);
    @(negedge clk);
    chk("t2_x0_rdy", 32'(exu_rdy), 32'd1);
    chk("t2_x0_en", 32'(wr_en), 32'd0);
    next_cyc();

    // Contention: EXU x7 continuously, one load to x5
    exu_set(1'b1, 5'd7, 32'h77);
    lsu_set(1'b1, 5'd5, 32'hAA);
    @(negedge clk);
    chk("t3_c0_addr", 32'(wr_addr), 32'd7);
    next_cyc();
    lsu_set(1'b0, 5'd0, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t3_exu_addr", 32'(wr_addr), 32'd7);
      chk("t3_exu_rdy", 32'(exu_rdy), 32'd1);
      next_cyc();
    end
    @(negedge clk);
    chk("t3_fifo_addr", 32'(wr_addr), 32'd5);
    chk("t3_fifo_data", wr_data, 32'hAA);
    chk("t3_fifo_rdy", 32'(exu_rdy), 32'd0);
    next_cyc();
    @(negedge clk);
    chk("t3_after_addr", 32'(wr_addr), 32'd7);
    chk("t3_after_cnt", 32'(cnt), 32'd0);
    next_cyc();
    drain();

    // WAW: pending x5=AA, EXU x5=BB
    lsu_set(1'b1, 5'd5, 32'hAA);
    next_cyc();
    lsu_set(1'b0, 5'd0, 32'd0);
    exu_set(1'b1, 5'd5, 32'hBB);
    @(negedge clk);
    chk("t4_first", wr_data, 32'hAA);
    chk("t4_first_rdy", 32'(exu_rdy), 32'd0);
    next_cyc();
    @(negedge clk);
    chk("t4_second", wr_data, 32'hBB);
    chk("t4_second_rdy", 32'(exu_rdy), 32'd1);
    next_cyc();
    exu_set(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("t4_final_x5", dut_rf[5], 32'hBB);
    next_cyc();
    drain();

    // Full FIFO: EXU busy on x7 keeps loads queued
    exu_set(1'b1, 5'd7, 32'h70);
    lsu_set(1'b1, 5'd1, 32'h101);
    next_cyc();
    lsu_set(1'b1, 5'd2, 32'h102);
    next_cyc();
    lsu_set(1'b1, 5'd3, 32'h103);
    @(negedge clk);
    chk("t5_full_rdy", 32'(lsu_rdy), 32'd0);
    chk("t5_full_cnt", 32'(cnt), 32'd2);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      next_cyc();
      @(negedge clk);
      found = lsu_rdy;
    end
    chk("t5_rdy_back", 32'(found), 32'd1);
    next_cyc();
    drain();
    lsu_set(1'b1, 5'd0, 32'h55);
    next_cyc();
    lsu_set(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("t5_x0_cnt", 32'(cnt), 32'd0);
    chk("t5_x0_en", 32'(wr_en), 32'd0);
    next_cyc();

    // Hazard against pending x9
    exu_set(1'b1, 5'd7, 32'h71);
    lsu_set(1'b1, 5'd9, 32'h99);
    next_cyc();
    lsu_set(1'b0, 5'd0, 32'd0);
    rs1 = 5'd9; rs2 = 5'd0;
    @(negedge clk);
`ifdef SCR1_MPRF_WR_ARB_BYPASS_EN
    chk("t6_stall", 32'(stall), 32'd0);
    chk("t6_b1_vd", 32'(b1_vd), 32'd1);
    chk("t6_b1_data", b1_data, 32'h99);
    chk("t6_b2_vd", 32'(b2_vd), 32'd0);
`else
    chk("t6_stall", 32'(stall), 32'd1);
`endif
    next_cyc();
    rs1 = 5'd0; rs2 = 5'd0;
    @(negedge clk);
    chk("t6_no_hit", 32'(stall), 32'd0);
    next_cyc();
    drain();

    // Reset mid-stream with two loads pending
    exu_set(1'b1, 5'd7, 32'h72);
    lsu_set(1'b1, 5'd1, 32'h201);
    next_cyc();
    lsu_set(1'b1, 5'd2, 32'h202);
    next_cyc();
    lsu_set(1'b0, 5'd0, 32'd0);
    rs1 = 5'd1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_wr_en", 32'(wr_en), 32'd0);
    chk("t1_addr", 32'(wr_addr), 32'd0);
    chk("t1_data", wr_data, 32'd0);
    chk("t1_lsu_rdy", 32'(lsu_rdy), 32'd1);
    chk("t1_stall", 32'(stall), 32'd0);
    chk("t1_cnt", 32'(cnt), 32'd0);
    chk("t1_exu_rdy", 32'(exu_rdy), 32'd1);
    exu_set(1'b0, 5'd0, 32'd0);
    rs1 = 5'd0;
    next_cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_no_old_wr", 32'(wr_en), 32'd0);
      next_cyc();
    end

    // Randomized traffic; EXU holds its request until accepted
    hold = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (!hold) exu_set($urandom_range(0, 9) < 7, 5'($urandom_range(0, 15)), $urandom);
      lsu_set($urandom_range(0, 1) == 1, 5'($urandom_range(0, 15)), $urandom);
      rs1 = 5'($urandom_range(0, 15));
      rs2 = 5'($urandom_range(0, 15));
      @(negedge clk);
      hold = exu_vd && !exu_rdy;
      next_cyc();
    end
    drain();

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_scr1_pipe_mprf_wr_arb
